pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter STACK_DEPTH, 4, return-stack entries; only used when CALL_STACK_EN is defined.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  inhibits issue of new fetch requests.
REQ-006 br_valid  input  1  branch/compare result valid this cycle.
REQ-007 jump  input  1  branch taken; qualified by br_valid; driven by the compare unit.
REQ-008 br_target  input  16  redirect address for a taken branch.
REQ-009 call, ret  input  1 each  call/return qualifiers; qualified by br_valid.
REQ-010 link_addr  input  16  return address pushed on call.
REQ-011 imem_req  output  1  fetch request; imem_addr  output  16  fetch address.
REQ-012 imem_ack  input  1  fetch completion; instruction data bypasses this block.
REQ-013 instr_valid  output  1  fetched word is valid for decode.
REQ-014 flush  output  1  one-cycle pulse on redirect; decode discards in-flight word.
REQ-015 pc  output  16  current fetch PC; stack_err  output  1  return-stack overflow/underflow pulse.

Function
REQ-016 FSM states: S_BOOT, S_FETCH, S_HOLD, S_REDIR; enum sits in the shared package.
REQ-017 S_BOOT: lasts exactly one cycle after reset release, imem_req=0, then goes to S_FETCH.
REQ-018 S_FETCH: imem_req=1, imem_addr=pc; request stays asserted with a stable address until imem_ack.
REQ-019 Ack in S_FETCH with no redirect: next cycle instr_valid=1 for one cycle; pc<=pc+1, 16'hFFFF wraps to 16'h0000.
REQ-020 Ack while stall=1: go to S_HOLD; imem_req=0; pc held. S_HOLD returns to S_FETCH on the first cycle with stall=0.
REQ-021 stall never aborts an outstanding request; the request completes normally.
REQ-022 Taken redirect (br_valid&jump): pc<=br_target; flush=1 the next cycle.
REQ-023 Redirect with a request outstanding and no ack: go to S_REDIR; keep the old request until ack; discard its data (instr_valid=0); then fetch br_target.
REQ-024 Redirect and ack in the same cycle: redirect wins; acked word discarded; pc<=br_target.
REQ-025 br_valid&!jump: no effect on pc, state or outputs.
REQ-026 Redirect during S_HOLD: pc updated and flush pulsed; the next fetch waits until stall=0.
REQ-027 Latency: a redirect at cycle N gives imem_addr=br_target no later than cycle N+1 when no request is outstanding.

Reset
REQ-028 rst_n low asynchronously forces: pc=RESET_PC, S_BOOT, imem_req=0, imem_addr=RESET_PC, instr_valid=0, flush=0, stack_err=0, stack empty.
REQ-029 Reset mid-request abandons the request; any ack that arrives later is ignored until S_FETCH.

Configuration
REQ-030 Macro CALL_STACK_EN compiles in the return stack.
REQ-031 With CALL_STACK_EN:
- br_valid&call pushes link_addr and redirects to br_target.
- br_valid&ret pops and redirects to the popped value; jump is ignored.
- Push on a full stack overwrites the oldest entry and pulses stack_err.
- ret on an empty stack redirects to br_target and pulses stack_err.
REQ-032 Without CALL_STACK_EN: call, ret and link_addr are ignored, stack_err is tied 0, and no stack storage is inferred.

Structure
REQ-033 Shared package cpu_pkg holds: the FSM state enum, an addr_t typedef (16-bit), and the RESET_PC and STACK_DEPTH defaults.
REQ-034 The return stack is one sub-module, ret_stack, instantiated only under CALL_STACK_EN.

Verification
REQ-035 Reset release, ack every cycle -> addresses 0000, 0001, 0002; instr_valid high from the third cycle after release.
REQ-036 pc=FFFF, ack -> next imem_addr=0000, no flush.
REQ-037 br_valid=1, jump=1, br_target=0x0040, same cycle as ack -> that word has instr_valid=0; flush pulse; next imem_addr=0x0040.
REQ-038 Redirect to 0x0100 with ack delayed 3 cycles -> imem_addr stays at the old value until ack; no instr_valid; then imem_addr=0x0100.
REQ-039 stall=1 for 4 cycles after an ack -> imem_req low for 4 cycles, pc unchanged; fetch resumes on the cycle stall falls.
REQ-040 CALL_STACK_EN: five calls (link 0x10..0x14), then five rets -> returns 0x14, 0x13, 0x12, 0x11; stack_err on the fifth call and the fifth ret.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the fetch front end.
// The optional return stack is compiled in with CALL_STACK_EN.
package cpu_pkg;

  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_REDIR = 2'd3
  } seq_state_t;

  localparam addr_t RESET_PC_DEF    = 16'h0000;
  localparam int    STACK_DEPTH_DEF = 4;

  // Sequential successor; 16'hFFFF wraps to 16'h0000 by truncation.
  function automatic addr_t pc_incr(input addr_t a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Only instantiated when CALL_STACK_EN is defined.
module ret_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  addr_t push_data,
  output addr_t top,
  output logic  empty,
  output logic  full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_idx_s;
  logic [PTR_W-1:0] wr_ptr_inc_s;
  logic [CNT_W-1:0] count_r;
  addr_t            mem_r [DEPTH];

  // Pointer arithmetic modulo DEPTH and status flags.
  always_comb begin
    if (wr_ptr_r == PTR_ZERO) begin
      rd_idx_s = LAST_IDX;
    end else begin
      rd_idx_s = wr_ptr_r - PTR_ONE;
    end
    if (wr_ptr_r == LAST_IDX) begin
      wr_ptr_inc_s = PTR_ZERO;
    end else begin
      wr_ptr_inc_s = wr_ptr_r + PTR_ONE;
    end
    top   = mem_r[rd_idx_s];
    empty = (count_r == CNT_ZERO);
    full  = (count_r == CNT_FULL);
  end

  // Entry storage; validity is tracked by count_r, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Write pointer and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (push) begin
      wr_ptr_r <= wr_ptr_inc_s;
      if (!full) begin
        count_r <= count_r + CNT_ONE;
      end
    end else if (pop && !empty) begin
      wr_ptr_r <= rd_idx_s;
      count_r  <= count_r - CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer with branch redirect and stall handling.
// Define CALL_STACK_EN to add the call/return stack (ret_stack).
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC    = RESET_PC_DEF,
  parameter int    STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        jump,
  input  logic [15:0] br_target,
  input  logic        call,
  input  logic        ret,
  input  logic [15:0] link_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic        flush,
  output logic [15:0] pc,
  output logic        stack_err
);

  seq_state_t state_r;
  addr_t      pc_r;
  addr_t      imem_addr_r;
  logic       imem_req_r;
  logic       instr_valid_r;
  logic       flush_r;

  logic       redir_s;
  addr_t      redir_tgt_s;
  addr_t      next_pc_s;
  addr_t      seq_pc_s;
  addr_t      fetch_addr_s;

`ifdef CALL_STACK_EN
  logic  push_s;
  logic  pop_s;
  logic  err_s;
  logic  stk_empty_s;
  logic  stk_full_s;
  addr_t stk_top_s;
  logic  stack_err_r;

  ret_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .pop      (pop_s),
    .push_data(link_addr),
    .top      (stk_top_s),
    .empty    (stk_empty_s),
    .full     (stk_full_s)
  );

  // Return-stack error pulse, aligned with the flush it accompanies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_err_r <= 1'b0;
    end else begin
      stack_err_r <= err_s;
    end
  end

  assign stack_err = stack_err_r;
`else
  logic unused_s;
  assign unused_s  = ^{call, ret, link_addr, (STACK_DEPTH > 0)};
  assign stack_err = 1'b0;
`endif

  // Redirect resolution; call takes precedence over ret, and ret over jump.
  always_comb begin
    redir_s     = 1'b0;
    redir_tgt_s = br_target;
`ifdef CALL_STACK_EN
    push_s = 1'b0;
    pop_s  = 1'b0;
    err_s  = 1'b0;
    if (br_valid && call) begin
      redir_s = 1'b1;
      push_s  = 1'b1;
      err_s   = stk_full_s;
    end else if (br_valid && ret) begin
      redir_s = 1'b1;
      if (stk_empty_s) begin
        err_s = 1'b1;
      end else begin
        pop_s       = 1'b1;
        redir_tgt_s = stk_top_s;
      end
    end else if (br_valid && jump) begin
      redir_s = 1'b1;
    end else begin
      redir_s = 1'b0;
    end
`else
    if (br_valid && jump) begin
      redir_s = 1'b1;
    end else begin
      redir_s = 1'b0;
    end
`endif
    seq_pc_s = pc_incr(pc_r);
    if (redir_s) begin
      next_pc_s = redir_tgt_s;
    end else begin
      next_pc_s = pc_r;
    end
    if ((state_r == S_FETCH) && imem_ack && !redir_s) begin
      fetch_addr_s = seq_pc_s;
    end else begin
      fetch_addr_s = next_pc_s;
    end
  end

  // Sequencer FSM with registered fetch and decode-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_BOOT;
      pc_r          <= RESET_PC;
      imem_addr_r   <= RESET_PC;
      imem_req_r    <= 1'b0;
      instr_valid_r <= 1'b0;
      flush_r       <= 1'b0;
    end else begin
      instr_valid_r <= 1'b0;
      flush_r       <= redir_s;
      if (redir_s) begin
        pc_r <= redir_tgt_s;
      end
      case (state_r)
        S_BOOT: begin
          state_r     <= S_FETCH;
          imem_req_r  <= 1'b1;
          imem_addr_r <= next_pc_s;
        end
        S_FETCH: begin
          if (imem_ack) begin
            if (!redir_s) begin
              instr_valid_r <= 1'b1;
              pc_r          <= seq_pc_s;
            end
            state_r     <= stall ? S_HOLD : S_FETCH;
            imem_req_r  <= !stall;
            imem_addr_r <= fetch_addr_s;
          end else if (redir_s) begin
            state_r <= S_REDIR;
          end
        end
        // The old request stays on the bus until acked; its data is dropped.
        S_REDIR: begin
          if (imem_ack) begin
            state_r     <= stall ? S_HOLD : S_FETCH;
            imem_req_r  <= !stall;
            imem_addr_r <= fetch_addr_s;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            state_r     <= S_FETCH;
            imem_req_r  <= 1'b1;
            imem_addr_r <= fetch_addr_s;
          end
        end
        default: begin
          state_r    <= S_BOOT;
          imem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign instr_valid = instr_valid_r;
  assign flush       = flush_r;
  assign pc          = pc_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer, plus hand-written sequences
// for reset-during-fetch and (with CALL_STACK_EN) the return stack.
module tb_pc_sequencer;

  typedef struct {
    logic        stall;
    logic        br_valid;
    logic        jump;
    logic        ack;
    logic [15:0] tgt;
    logic        req;
    logic        iv;
    logic        fl;
    logic [15:0] addr;
    logic [15:0] pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [15:0] link_addr = 16'h0000;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        instr_valid;
  logic        flush;
  logic [15:0] pc;
  logic        stack_err;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs [26];

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_valid   (br_valid),
    .jump       (jump),
    .br_target  (br_target),
    .call       (call),
    .ret        (ret),
    .link_addr  (link_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .instr_valid(instr_valid),
    .flush      (flush),
    .pc         (pc),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mv(input logic st, input logic bv, input logic jp, input logic ak,
                              input logic [15:0] tg, input logic rq, input logic iv,
                              input logic fl, input logic [15:0] ad, input logic [15:0] pcv);
    vec_t v;
    v.stall = st; v.br_valid = bv; v.jump = jp; v.ack = ak; v.tgt = tg;
    v.req = rq; v.iv = iv; v.fl = fl; v.addr = ad; v.pc = pcv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    br_valid = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    br_target = 16'h0000; link_addr = 16'h0000;
  endtask

  initial begin
    // stall, br_valid, jump, ack, target | req, instr_valid, flush, addr, pc
    vecs[0]  = mv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    vecs[1]  = mv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001);
    vecs[2]  = mv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0002);
    vecs[3]  = mv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0003);
    vecs[4]  = mv(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0040);
    vecs[5]  = mv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0040);
    vecs[6]  = mv(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0040);
    vecs[7]  = mv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0041, 16'h0041);
    vecs[8]  = mv(1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b1, 16'h0041, 16'h0100);
    vecs[9]  = mv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0041, 16'h0100);
    vecs[10] = mv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0041, 16'h0100);
    vecs[11] = mv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100);
    vecs[12] = mv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0101, 16'h0101);
    vecs[13] = mv(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0102);
    vecs[14] = mv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0102);
    vecs[15] = mv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0102);
    vecs[16] = mv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0102);
    vecs[17] = mv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0102, 16'h0102);
    vecs[18] = mv(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0103);
    vecs[19] = mv(1'b1, 1'b1, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0200);
    vecs[20] = mv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0200);
    vecs[21] = mv(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0200);
    vecs[22] = mv(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0200, 16'hFFFF);
    vecs[23] = mv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    vecs[24] = mv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    vecs[25] = mv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",  {15'd0, imem_req},    16'h0000);
    chk("rst_addr", imem_addr,            16'h0000);
    chk("rst_pc",   pc,                   16'h0000);
    chk("rst_iv",   {15'd0, instr_valid}, 16'h0000);
    chk("rst_fl",   {15'd0, flush},       16'h0000);
    chk("rst_err",  {15'd0, stack_err},   16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      stall = vecs[i].stall; br_valid = vecs[i].br_valid; jump = vecs[i].jump;
      imem_ack = vecs[i].ack; br_target = vecs[i].tgt;
      step();
      chk($sformatf("v%0d_req", i), {15'd0, imem_req},    {15'd0, vecs[i].req});
      chk($sformatf("v%0d_iv", i),  {15'd0, instr_valid}, {15'd0, vecs[i].iv});
      chk($sformatf("v%0d_fl", i),  {15'd0, flush},       {15'd0, vecs[i].fl});
      chk($sformatf("v%0d_pc", i),  pc,                   vecs[i].pc);
      chk($sformatf("v%0d_err", i), {15'd0, stack_err},   16'h0000);
      if (vecs[i].req) begin
        chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      end
    end
    stall = 1'b0; imem_ack = 1'b0;
    clear_br();

`ifdef CALL_STACK_EN
    // Five calls into a four-deep stack, then five returns.
    for (int i = 0; i < 5; i++) begin
      br_valid = 1'b1; call = 1'b1;
      link_addr = 16'h0010 + 16'(i); br_target = 16'h0300 + 16'(i);
      step();
      chk($sformatf("call%0d_pc", i),  pc,                 16'h0300 + 16'(i));
      chk($sformatf("call%0d_fl", i),  {15'd0, flush},     16'h0001);
      chk($sformatf("call%0d_err", i), {15'd0, stack_err}, (i == 4) ? 16'h0001 : 16'h0000);
    end
    clear_br();
    for (int i = 0; i < 5; i++) begin
      br_valid = 1'b1; ret = 1'b1; jump = 1'b1; br_target = 16'h0500;
      step();
      chk($sformatf("ret%0d_pc", i),   pc,                 (i < 4) ? 16'h0014 - 16'(i) : 16'h0500);
      chk($sformatf("ret%0d_err", i),  {15'd0, stack_err}, (i == 4) ? 16'h0001 : 16'h0000);
      chk($sformatf("ret%0d_addr", i), imem_addr,          16'h0001);
    end
    clear_br();
    imem_ack = 1'b1;
    step();
    chk("stk_resume_addr", imem_addr,            16'h0500);
    chk("stk_resume_iv",   {15'd0, instr_valid}, 16'h0000);
    imem_ack = 1'b0;
`else
    // call/ret without the stack build must be inert.
    br_valid = 1'b1; call = 1'b1; link_addr = 16'h0010; br_target = 16'h0300;
    step();
    chk("nocall_pc",  pc,                 16'h0001);
    chk("nocall_fl",  {15'd0, flush},     16'h0000);
    chk("nocall_err", {15'd0, stack_err}, 16'h0000);
    call = 1'b0; ret = 1'b1;
    step();
    chk("noret_pc", pc,             16'h0001);
    chk("noret_fl", {15'd0, flush}, 16'h0000);
    clear_br();
`endif

    // Reset in the middle of an outstanding request; a late ack is ignored.
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk("arst_req",  {15'd0, imem_req},    16'h0000);
    chk("arst_addr", imem_addr,            16'h0000);
    chk("arst_pc",   pc,                   16'h0000);
    chk("arst_iv",   {15'd0, instr_valid}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("boot_req",  {15'd0, imem_req},    16'h0001);
    chk("boot_addr", imem_addr,            16'h0000);
    chk("boot_pc",   pc,                   16'h0000);
    chk("boot_iv",   {15'd0, instr_valid}, 16'h0000);
    step();
    chk("post_addr", imem_addr,            16'h0001);
    chk("post_iv",   {15'd0, instr_valid}, 16'h0001);
    imem_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
